// File: rtl/qif_pkg.sv
// Shared types, constants and saturation helper for the QIF neuron/synapse slice.
package qif_pkg;

  typedef logic signed [7:0] v_t;
  typedef logic signed [7:0] cur_t;

  typedef enum logic {
    ST_ARMED  = 1'b0,
    ST_REFRAC = 1'b1
  } syn_state_t;

  localparam v_t V_PEAK  = 8'sd50;
  localparam v_t V_RESET = -8'sd20;

  // Clamp a 9-bit signed sum into the 8-bit signed range.
  function automatic cur_t sat8(input logic signed [8:0] x);
    if (x > 9'sd127) begin
      return 8'sd127;
    end else if (x < -9'sd128) begin
      return -8'sd128;
    end
    return cur_t'(x[7:0]);
  endfunction

endpackage

// File: rtl/qif_decay_unit.sv
// Combinational exponential decay step: I_dec = I - (I >>> TAU_SHIFT) on a tick.
module qif_decay_unit
  import qif_pkg::*;
#(
  parameter int TAU_SHIFT = 2
) (
  input  cur_t i_syn,
  input  logic tick,
  output cur_t i_dec
);

  cur_t shifted;
  cur_t delta;

  // Positive values would stall at small magnitudes without a minimum step of 1;
  // negative values already reach -1 from the arithmetic shift and hit zero on their own.
  always_comb begin
    shifted = i_syn >>> TAU_SHIFT;
    delta   = shifted;
    if ((shifted == 8'sd0) && (i_syn > 8'sd0)) begin
      delta = 8'sd1;
    end
    i_dec = tick ? cur_t'(i_syn - delta) : i_syn;
  end

endmodule

// File: rtl/qif_synapse.sv
// Synaptic current generator: spike detection with refractory window feeding a
// saturating, exponentially decaying current accumulator.
module qif_synapse
  import qif_pkg::*;
#(
  parameter int THRESH    = 50,
  parameter int REFRAC    = 4,
  parameter int TAU_SHIFT = 2,
  parameter int DECAY_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  v_t         V_pre,
  input  cur_t       weight,
  output cur_t       I_syn,
  output logic       spike_out,
  output logic [7:0] spike_cnt
);

  localparam v_t         TH      = v_t'(THRESH);
  localparam logic [7:0] PRE_MAX = 8'(DECAY_DIV - 1);
  localparam logic [7:0] RC_INIT = (REFRAC > 0) ? 8'(REFRAC - 1) : 8'd0;
  localparam logic       HAS_REF = (REFRAC > 0);

  syn_state_t        state, state_nxt;
  logic [7:0]        rcnt, rcnt_nxt;
  logic [7:0]        pre, pre_nxt;
  v_t                v_prev;
  cur_t              i_dec, i_nxt;
  logic signed [8:0] sum;
  logic              det, tick;

  // Upward crossing only: a level held above threshold never re-fires.
  assign det  = en && (state == ST_ARMED) && (V_pre >= TH) && (v_prev < TH);
  assign tick = (pre == PRE_MAX);

  qif_decay_unit #(.TAU_SHIFT(TAU_SHIFT)) u_decay (
    .i_syn (I_syn),
    .tick  (tick),
    .i_dec (i_dec)
  );

  // State register; spike_out updates even when disabled so it drops to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_ARMED;
      rcnt      <= 8'd0;
      pre       <= 8'd0;
      v_prev    <= 8'sd0;
      I_syn     <= 8'sd0;
      spike_cnt <= 8'd0;
      spike_out <= 1'b0;
    end else begin
      spike_out <= det;
      if (en) begin
        state     <= state_nxt;
        rcnt      <= rcnt_nxt;
        pre       <= pre_nxt;
        v_prev    <= V_pre;
        I_syn     <= i_nxt;
        spike_cnt <= spike_cnt + {7'd0, det};
      end
    end
  end

  // Next-state logic for the refractory FSM.
  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt;
    case (state)
      ST_ARMED: begin
        if (det && HAS_REF) begin
          state_nxt = ST_REFRAC;
          rcnt_nxt  = RC_INIT;
        end
      end
      ST_REFRAC: begin
        if (rcnt == 8'd0) begin
          state_nxt = ST_ARMED;
        end else begin
          rcnt_nxt = rcnt - 8'd1;
        end
      end
      default: begin
        state_nxt = ST_ARMED;
        rcnt_nxt  = 8'd0;
      end
    endcase
  end

  // Datapath next values: decay first, then the weight on a spike.
  always_comb begin
    sum     = $signed({i_dec[7], i_dec}) + $signed({weight[7], weight});
    i_nxt   = det ? sat8(sum) : i_dec;
    pre_nxt = tick ? 8'd0 : (pre + 8'd1);
  end

endmodule

// File: tb/tb_qif_synapse.sv
// Scoreboard bench for qif_synapse: three prescaler configurations driven in lockstep.
module tb_qif_synapse;
  import qif_pkg::*;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  v_t         V_pre = 8'sd0;
  cur_t       weight = 8'sd0;
  cur_t       i_o  [NI];
  logic       sp_o [NI];
  logic [7:0] c_o  [NI];

  cur_t du_i;
  logic du_tick;
  cur_t du_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [16:0] exp_q[$];

  int p_div   [NI] = '{4, 1, 255};
  int m_vprev [NI];
  int m_armed [NI];
  int m_rc    [NI];
  int m_pre   [NI];
  int m_i     [NI];
  int m_cnt   [NI];

  always #5 clk = ~clk;

  qif_synapse #(.DECAY_DIV(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .V_pre(V_pre), .weight(weight),
    .I_syn(i_o[0]), .spike_out(sp_o[0]), .spike_cnt(c_o[0]));
  qif_synapse #(.DECAY_DIV(1)) dut_f (
    .clk(clk), .rst_n(rst_n), .en(en), .V_pre(V_pre), .weight(weight),
    .I_syn(i_o[1]), .spike_out(sp_o[1]), .spike_cnt(c_o[1]));
  qif_synapse #(.DECAY_DIV(255)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .V_pre(V_pre), .weight(weight),
    .I_syn(i_o[2]), .spike_out(sp_o[2]), .spike_cnt(c_o[2]));

  qif_decay_unit #(.TAU_SHIFT(2)) u_du (.i_syn(du_i), .tick(du_tick), .i_dec(du_o));

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat_ref(input int x);
    if (x > 127) return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  function automatic int dec_ref(input int x);
    int d;
    d = x >>> 2;
    if (d == 0 && x > 0) d = 1;
    return x - d;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_vprev[k] = 0; m_armed[k] = 1; m_rc[k] = 0;
      m_pre[k] = 0;   m_i[k] = 0;     m_cnt[k] = 0;
    end
  endtask

  // Drive one cycle, predict the post-edge outputs, then compare after the edge.
  task automatic step(input logic e, input int v, input int w);
    int d, det, tick, sp;
    logic [16:0] ent;
    logic [16:0] got;
    logic [31:0] iv, cv;
    en = e;
    V_pre = v_t'(v);
    weight = cur_t'(w);
    for (int k = 0; k < NI; k++) begin
      sp = 0;
      if (!rst_n) begin
        m_vprev[k] = 0; m_armed[k] = 1; m_rc[k] = 0;
        m_pre[k] = 0;   m_i[k] = 0;     m_cnt[k] = 0;
      end else if (e) begin
        det  = (m_armed[k] == 1 && v >= 50 && m_vprev[k] < 50) ? 1 : 0;
        tick = (m_pre[k] == p_div[k] - 1) ? 1 : 0;
        d    = tick ? dec_ref(m_i[k]) : m_i[k];
        m_i[k]   = det ? sat_ref(d + w) : d;
        m_pre[k] = tick ? 0 : m_pre[k] + 1;
        if (m_armed[k] == 1) begin
          if (det == 1) begin m_armed[k] = 0; m_rc[k] = 3; end
        end else if (m_rc[k] == 0) begin
          m_armed[k] = 1;
        end else begin
          m_rc[k] = m_rc[k] - 1;
        end
        m_vprev[k] = v;
        m_cnt[k]   = (m_cnt[k] + det) % 256;
        sp = det;
      end
      iv = m_i[k];
      cv = m_cnt[k];
      ent = {iv[7:0], sp[0], cv[7:0]};
      exp_q.push_back(ent);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      if (exp_q.size() == 0) begin
        chk("queue_empty", 0, 1);
      end else begin
        ent = exp_q.pop_front();
        got = {i_o[k], sp_o[k], c_o[k]};
        chk($sformatf("isyn%0d", k), int'($signed(got[16:9])), int'($signed(ent[16:9])));
        chk($sformatf("spike%0d", k), int'(got[8]), int'(ent[8]));
        chk($sformatf("cnt%0d", k), int'(got[7:0]), int'(ent[7:0]));
      end
    end
  endtask

  int tab_pos[19] = '{100, 75, 57, 43, 33, 25, 19, 15, 12, 9, 7, 6, 5, 4, 3, 2, 1, 0, 0};
  int tab_neg[16] = '{-100, -75, -56, -42, -31, -23, -17, -12, -9, -6, -4, -3, -2, -1, 0, 0};

  initial begin
    model_reset();
    // Reset held with V_pre high: outputs stay zero.
    rst_n = 1'b0;
    for (int j = 0; j < 3; j++) step(1'b1, 60, 40);
    #3 rst_n = 1'b1;
    for (int j = 0; j < 10; j++) step(1'b1, 60, 40);
    chk("post_reset_cnt", int'(c_o[0]), 1);

    // Single spike from V_RESET to V_PEAK.
    for (int j = 0; j < 10; j++) step(1'b1, -20, 40);
    step(1'b1, 50, 40);
    chk("single_spike", int'(sp_o[0]), 1);
    for (int j = 0; j < 4; j++) step(1'b1, -20, 40);

    // Long quiet period so the fast-decay instance returns to zero.
    for (int j = 0; j < 40; j++) step(1'b1, -20, 0);
    step(1'b1, 60, 100);
    for (int j = 0; j < 19; j++) begin
      chk($sformatf("decay_pos[%0d]", j), int'(i_o[1]), tab_pos[j]);
      step(1'b1, -20, 100);
    end
    step(1'b1, 60, -100);
    for (int j = 0; j < 16; j++) begin
      chk($sformatf("decay_neg[%0d]", j), int'(i_o[1]), tab_neg[j]);
      step(1'b1, -20, -100);
    end

    // Saturation: repeated crossings six cycles apart.
    for (int s = 0; s < 4; s++) begin
      step(1'b1, 60, 100);
      for (int j = 0; j < 5; j++) step(1'b1, 0, 100);
    end
    chk("sat_hi", int'(i_o[2]), 127);
    for (int s = 0; s < 5; s++) begin
      step(1'b1, 60, -100);
      for (int j = 0; j < 5; j++) step(1'b1, 0, -100);
    end
    chk("sat_lo", int'(i_o[2]), -128);

    // Refractory: toggling input, then a held high level.
    for (int j = 0; j < 24; j++) step(1'b1, (j % 2 == 0) ? 60 : 0, 10);
    for (int j = 0; j < 4; j++) step(1'b1, 0, 10);
    for (int j = 0; j < 12; j++) step(1'b1, 60, 10);

    // Enable low mid-decay with crossings that must be ignored.
    for (int j = 0; j < 4; j++) step(1'b1, 0, 0);
    step(1'b1, 60, 100);
    for (int j = 0; j < 2; j++) step(1'b1, 0, 0);
    for (int j = 0; j < 8; j++) step(1'b0, (j % 2 == 0) ? 0 : 60, 50);
    for (int j = 0; j < 10; j++) step(1'b1, 0, 0);

    // Async reset between edges while the fast instance holds 57.
    for (int j = 0; j < 30; j++) step(1'b1, 0, 0);
    step(1'b1, 60, 100);
    step(1'b1, 0, 0);
    step(1'b1, 0, 0);
    chk("pre_rst_57", int'(i_o[1]), 57);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("async_isyn%0d", k), int'(i_o[k]), 0);
      chk($sformatf("async_cnt%0d", k), int'(c_o[k]), 0);
    end
    step(1'b1, 60, 30);
    #2 rst_n = 1'b1;
    for (int j = 0; j < 4; j++) step(1'b1, 60, 30);

    // Random traffic.
    for (int j = 0; j < 300; j++) begin
      step(($urandom_range(0, 9) != 0), int'($signed(8'($urandom_range(0, 255)))),
           int'($signed(8'($urandom_range(0, 255)))));
    end

    // Exhaustive decay unit sweep.
    for (int t = 0; t < 2; t++) begin
      for (int x = -128; x < 128; x++) begin
        du_i = cur_t'(x);
        du_tick = t[0];
        #1;
        chk($sformatf("du[%0d,%0d]", t, x), int'(du_o), (t == 1) ? dec_ref(x) : x);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
